// File: rtl/prescale_arbiter.sv
// prescale_arbiter: round-robin arbiter that lends the shared I2C clock
// prescaler to one of two requesters for a counted number of output periods.
// Optional watchdog abort is compiled in with `define PRESCALE_ARB_TIMEOUT_EN.
module prescale_arbiter #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [3:0]       sel0,
  input  logic [3:0]       sel1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic             pre_out,
  output logic             pre_en,
  output logic [3:0]       pre_sel,
  output logic             gnt0,
  output logic             gnt1,
  output logic             owner,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD1 = 3'd1,
    LOAD2 = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state, state_d;
  logic             ptr, ptr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt, cnt_d, cnt_inc;
  logic             pre_q, pre_q_d;
  logic             pre_en_d, gnt0_d, gnt1_d, owner_d, busy_d, done_d, err_d;
  logic [3:0]       pre_sel_d;
  logic             owner_req;
  logic             fall;
  logic             wd_expired;

  assign owner_req = owner ? req1 : req0;
  assign fall      = pre_q & ~pre_out;
  assign cnt_inc   = (fall && (cnt != '1)) ? cnt + LEN_W'(1) : cnt;

`ifdef PRESCALE_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = 6;
  logic [WD_W-1:0] wd;

  // Watchdog: RUN cycles since the last prescaler falling edge.
  always_ff @(posedge clk) begin
    if (rst || (state != RUN) || fall) begin
      wd <= '0;
    end else begin
      wd <= wd + WD_W'(1);
    end
  end

  assign wd_expired = (state == RUN) && !fall && (wd == '1);
`else
  assign wd_expired = 1'b0;
`endif

  // Next-state and next-output decode.
  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    len_d     = len_q;
    cnt_d     = '0;
    pre_q_d   = 1'b0;
    pre_sel_d = pre_sel;
    owner_d   = owner;
    gnt0_d    = gnt0;
    gnt1_d    = gnt1;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          owner_d   = (req0 && req1) ? ptr : req1;
          pre_sel_d = owner_d ? sel1 : sel0;
          len_d     = owner_d ? len1 : len0;
          if (len_d == '0) begin
            len_d = LEN_W'(1);
          end
          gnt0_d  = ~owner_d;
          gnt1_d  = owner_d;
          state_d = LOAD1;
        end
      end
      LOAD1: state_d = LOAD2;
      LOAD2: state_d = RUN;
      RUN: begin
        pre_q_d = pre_out;
        cnt_d   = cnt_inc;
        if (cnt_inc == len_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          ptr_d   = ~owner;
        end else if (wd_expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
          ptr_d   = ~owner;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Owner withdrawing its request cancels the burst silently.
    if (((state == LOAD1) || (state == LOAD2) || (state == RUN)) && !owner_req) begin
      state_d = IDLE;
      done_d  = 1'b0;
      err_d   = 1'b0;
      ptr_d   = ~owner;
      pre_q_d = 1'b0;
      cnt_d   = '0;
    end

    busy_d   = (state_d == LOAD1) || (state_d == LOAD2) || (state_d == RUN);
    pre_en_d = (state_d == RUN);
    if (!busy_d) begin
      gnt0_d = 1'b0;
      gnt1_d = 1'b0;
    end
  end

  // State, working registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      len_q   <= '0;
      cnt     <= '0;
      pre_q   <= 1'b0;
      pre_en  <= 1'b0;
      pre_sel <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      owner   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      len_q   <= len_d;
      cnt     <= cnt_d;
      pre_q   <= pre_q_d;
      pre_en  <= pre_en_d;
      pre_sel <= pre_sel_d;
      gnt0    <= gnt0_d;
      gnt1    <= gnt1_d;
      owner   <= owner_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_prescale_arbiter.sv
// tb_prescale_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a burst-level model built from the timing formulas.
module tb_prescale_arbiter;

  localparam int unsigned LEN_W = 8;

  logic             clk  = 1'b0;
  logic             rst  = 1'b1;
  logic             req0 = 1'b0;
  logic             req1 = 1'b0;
  logic [3:0]       sel0 = '0;
  logic [3:0]       sel1 = '0;
  logic [LEN_W-1:0] len0 = '0;
  logic [LEN_W-1:0] len1 = '0;
  logic             pre_out;
  logic             pre_en;
  logic [3:0]       pre_sel;
  logic             gnt0, gnt1, owner, busy, done, err;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  prescale_arbiter #(.LEN_W(LEN_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .req1    (req1),
    .sel0    (sel0),
    .sel1    (sel1),
    .len0    (len0),
    .len1    (len1),
    .pre_out (pre_out),
    .pre_en  (pre_en),
    .pre_sel (pre_sel),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .owner   (owner),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  // Prescaler stand-in: M = sel+1, period 2M+1, high for the last M counts, cleared while disabled.
  int pc = 0;
  always @(posedge clk) begin
    if (!pre_en) pc <= 0;
    else if (pc >= 2 * (int'(pre_sel) + 1)) pc <= 0;
    else pc <= pc + 1;
  end
  assign pre_out = pre_en && (pc >= int'(pre_sel) + 2);

  // Burst-level model: mode 0 idle, 1 granted (t counts cycles since grant), 2 done cycle.
  typedef struct {
    int         mode;
    int         t;
    int         runlen;
    bit         own;
    bit         ptr;
    logic [3:0] sel;
  } model_t;

  model_t m = '{0, 0, 0, 1'b0, 1'b0, 4'd0};

  function automatic model_t step(input model_t s);
    model_t n;
    int     l;
    bit     w;
    n = s;
    if (rst) begin
      n.mode = 0; n.t = 0; n.own = 1'b0; n.ptr = 1'b0; n.sel = '0;
      return n;
    end
    case (s.mode)
      0: if (req0 || req1) begin
        w      = (req0 && req1) ? s.ptr : req1;
        n.own  = w;
        n.sel  = w ? sel1 : sel0;
        l      = int'(w ? len1 : len0);
        if (l == 0) l = 1;
        n.runlen = l * (2 * (int'(n.sel) + 1) + 1) + 1;
        n.t    = 1;
        n.mode = 1;
      end
      1: begin
        if (!(s.own ? req1 : req0)) begin
          n.mode = 0; n.ptr = !s.own;
        end else if (s.t == s.runlen + 2) begin
          n.mode = 2; n.ptr = !s.own;
        end else begin
          n.t = s.t + 1;
        end
      end
      default: n.mode = 0;
    endcase
    return n;
  endfunction

  always @(posedge clk) m <= step(m);

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt0",    int'(gnt0),    int'(m.mode == 1 && !m.own));
      check("gnt1",    int'(gnt1),    int'(m.mode == 1 && m.own));
      check("busy",    int'(busy),    int'(m.mode == 1));
      check("pre_en",  int'(pre_en),  int'(m.mode == 1 && m.t >= 3));
      check("done",    int'(done),    int'(m.mode == 2));
      check("err",     int'(err),     0);
      check("owner",   int'(owner),   int'(m.own));
      check("pre_sel", int'(pre_sel), int'(m.sel));
    end
  end

  task automatic measure(input string nm, output int run);
    int n;
    n = 0; run = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
      if (pre_en) run++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s: no done within %0d cycles", nm, n);
    end
  endtask

  task automatic wait_pre_en(input string nm);
    int n;
    n = 0;
    while (!pre_en && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!pre_en) begin
      checks++; errors++;
      $display("FAIL %s: no pre_en within %0d cycles", nm, n);
    end
  endtask

  initial begin
    int run;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_outputs", int'({pre_en, pre_sel, gnt0, gnt1, owner, busy, done, err}), 0);
    rst = 1'b0;

    // Single request, M=1, two periods.
    req0 = 1'b1; sel0 = 4'd0; len0 = LEN_W'(2);
    @(negedge clk);
    check("single_gnt0", int'(gnt0), 1);
    check("single_pre_en_low", int'(pre_en), 0);
    measure("single", run);
    check("single_run_cycles", run, 7);
    check("single_gnt_at_done", int'(gnt0), 0);
    req0 = 1'b0;
    @(negedge clk);

    // Contention straight after reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    sel0 = 4'd2; len0 = LEN_W'(1); sel1 = 4'd5; len1 = LEN_W'(1);
    @(negedge clk);
    check("contend_first", int'({gnt0, gnt1}), 2);
    measure("contend_a", run);
    @(negedge clk);
    check("contend_gap", int'({gnt0, gnt1}), 0);
    @(negedge clk);
    check("contend_gnt1", int'({gnt0, gnt1}), 1);
    check("contend_sel1", int'(pre_sel), 5);
    measure("contend_b", run);
    @(negedge clk);
    @(negedge clk);
    check("contend_gnt0_again", int'({gnt0, gnt1}), 2);
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);

    // Zero length is one period: M=4 gives 10 RUN cycles.
    req1 = 1'b1; sel1 = 4'd3; len1 = '0;
    @(negedge clk);
    check("zero_gnt1", int'(gnt1), 1);
    measure("zero", run);
    check("zero_run_cycles", run, 10);
    req1 = 1'b0;
    @(negedge clk);

    // Owner drops its request in the third RUN cycle.
    req0 = 1'b1; req1 = 1'b1;
    sel0 = 4'd1; len0 = LEN_W'(3); sel1 = 4'd0; len1 = LEN_W'(1);
    wait_pre_en("abort_run");
    @(negedge clk);
    @(negedge clk);
    check("abort_owner", int'(gnt0), 1);
    req0 = 1'b0;
    @(negedge clk);
    check("abort_pre_en", int'(pre_en), 0);
    check("abort_gnt0", int'(gnt0), 0);
    check("abort_no_done", int'(done), 0);
    @(negedge clk);
    check("abort_gnt1", int'(gnt1), 1);
    measure("abort_b", run);
    req1 = 1'b0;
    @(negedge clk);

    // Reset mid-RUN restores the pointer to requester 0.
    req0 = 1'b1; sel0 = 4'd0; len0 = LEN_W'(1);
    @(negedge clk);
    measure("pre_rst", run);
    req0 = 1'b0;
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; sel1 = 4'd2; len1 = LEN_W'(2);
    wait_pre_en("rstrun_run");
    check("rstrun_owner1", int'(gnt1), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstrun_outputs", int'({pre_en, pre_sel, gnt0, gnt1, owner, busy, done, err}), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rstrun_regrant", int'({gnt0, gnt1}), 2);
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);

    // Randomized traffic: owners mostly hold, occasionally abort; latched fields keep changing.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst  = ($urandom_range(0, 799) == 0);
      req0 = gnt0 ? ($urandom_range(0, 59) != 0) : ($urandom_range(0, 2) != 0);
      req1 = gnt1 ? ($urandom_range(0, 59) != 0) : ($urandom_range(0, 2) != 0);
      sel0 = 4'($urandom_range(0, 15));
      sel1 = 4'($urandom_range(0, 15));
      len0 = LEN_W'($urandom_range(0, 4));
      len1 = LEN_W'($urandom_range(0, 4));
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
